// File: rtl/instr_mem_loader.sv
// Streams a program image into the byte-wide instruction memory, checks its
// trailing 8-bit checksum and holds the CPU stalled while the image is incomplete.
module instr_mem_loader #(
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   len,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     cpu_stall,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned LEN_W = ADDRESS_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t                   state, state_d;
    logic [LEN_W-1:0]         remaining, remaining_d;
    logic [ADDRESS_WIDTH-1:0] addr, addr_d;
    logic [DATA_WIDTH-1:0]    csum, csum_d;

    logic                     we_d;
    logic [ADDRESS_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0]    wdata_d;
    logic                     ready_d;
    logic                     stall_d;
    logic                     done_d;
    logic                     err_d;

    logic                     xfer_c;
    logic [DATA_WIDTH-1:0]    sum_c;

    // in_ready is a registered copy of "state is LOAD or CHECK"
    assign xfer_c = in_valid && in_ready;
    assign sum_c  = csum + in_data;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            addr      <= '0;
            csum      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_stall <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
            addr      <= addr_d;
            csum      <= csum_d;
            in_ready  <= ready_d;
            mem_we    <= we_d;
            mem_addr  <= waddr_d;
            mem_wdata <= wdata_d;
            cpu_stall <= stall_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Next-state, counter updates and next output values
    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        addr_d      = addr;
        csum_d      = csum;
        we_d        = 1'b0;
        waddr_d     = mem_addr;
        wdata_d     = mem_wdata;

        unique case (state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    if (len > MAX_LEN) begin
                        state_d = ST_ERR;
                    end else begin
                        remaining_d = len;
                        addr_d      = '0;
                        csum_d      = '0;
                        state_d     = (len == '0) ? ST_CHECK : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer_c) begin
                    we_d        = 1'b1;
                    waddr_d     = addr;
                    wdata_d     = in_data;
                    addr_d      = addr + ADDRESS_WIDTH'(1);
                    csum_d      = sum_c;
                    remaining_d = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                // The checksum byte only feeds the compare; it is never written
                if (xfer_c) begin
                    state_d = (sum_c == '0) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        stall_d = (state_d == ST_LOAD) || (state_d == ST_CHECK) || (state_d == ST_ERR);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERR);
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: reset, nominal load, checksum error,
// gapped stream, length boundaries and ignored start.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_stall;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int done_count = 0;
    logic [7:0] tbmem [0:4095];
    logic [7:0] csum;
    logic [7:0] last_byte;

    instr_mem_loader #(.ADDRESS_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_stall (cpu_stall),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory model fed by the write port
    always @(posedge clk) begin
        if (mem_we) begin
            wr_count = wr_count + 1;
            tbmem[mem_addr] = mem_wdata;
        end
        if (done) done_count = done_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [12:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [11:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(mem_wdata), 32'(d));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        step(); step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        step();

        // Reset in the middle of a 4-byte load
        do_start(13'd4);
        in_valid = 1'b1; in_data = 8'h11; step();
        in_data = 8'h22; step();
        chk_write("mid_w1", 12'd1, 8'h22);
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        step(); step();

        // Nominal 4-byte load
        wr_count = 0; done_count = 0;
        do_start(13'd4);
        chk("nom_ready", 32'(in_ready), 32'd1);
        chk("nom_stall_c2", 32'(cpu_stall), 32'd1);
        chk("nom_we_c2", 32'(mem_we), 32'd0);
        in_valid = 1'b1; in_data = 8'h13; step();
        chk_write("nom_w0", 12'd0, 8'h13);
        in_data = 8'h00; step();
        chk_write("nom_w1", 12'd1, 8'h00);
        in_data = 8'h50; step();
        chk_write("nom_w2", 12'd2, 8'h50);
        in_data = 8'h00; step();
        chk_write("nom_w3", 12'd3, 8'h00);
        chk("nom_stall_c6", 32'(cpu_stall), 32'd1);
        in_data = 8'h9D; step();
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_stall_c7", 32'(cpu_stall), 32'd0);
        chk("nom_err", 32'(err), 32'd0);
        chk("nom_we_c7", 32'(mem_we), 32'd0);
        in_valid = 1'b0; step();
        chk("nom_done_c8", 32'(done), 32'd0);
        chk("nom_wr_count", 32'(wr_count), 32'd4);
        chk("nom_done_count", 32'(done_count), 32'd1);
        chk("nom_word0", {tbmem[3], tbmem[2], tbmem[1], tbmem[0]}, 32'h0050_0013);

        // Bad checksum
        done_count = 0;
        do_start(13'd4);
        in_valid = 1'b1;
        in_data = 8'h13; step();
        in_data = 8'h00; step();
        in_data = 8'h50; step();
        in_data = 8'h00; step();
        in_data = 8'h00; step();
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_stall", 32'(cpu_stall), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        in_valid = 1'b0;
        step(); step(); step();
        chk("bad_err_sticky", 32'(err), 32'd1);
        chk("bad_stall_sticky", 32'(cpu_stall), 32'd1);
        chk("bad_ready", 32'(in_ready), 32'd0);
        chk("bad_done_count", 32'(done_count), 32'd0);

        // len = 0 from ERR clears err and needs only the checksum byte
        wr_count = 0;
        do_start(13'd0);
        chk("len0_err_clr", 32'(err), 32'd0);
        chk("len0_ready", 32'(in_ready), 32'd1);
        chk("len0_stall", 32'(cpu_stall), 32'd1);
        in_valid = 1'b1; in_data = 8'h00; step();
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0; step();
        chk("len0_wr_count", 32'(wr_count), 32'd0);

        // len = 4097 is rejected
        do_start(13'd4097);
        chk("len4097_err", 32'(err), 32'd1);
        chk("len4097_ready", 32'(in_ready), 32'd0);
        chk("len4097_stall", 32'(cpu_stall), 32'd1);
        in_valid = 1'b1; in_data = 8'h55; step();
        chk("len4097_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0; step();

        // Gapped 3-byte stream: AA, gap, gap, BB, CC, checksum CF
        wr_count = 0;
        do_start(13'd3);
        in_valid = 1'b1; in_data = 8'hAA; step();
        in_valid = 1'b0;
        chk_write("gap_w0", 12'd0, 8'hAA);
        step();
        chk("gap_we_idle", 32'(mem_we), 32'd0);
        chk("gap_ready_hold", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'hBB; step();
        chk_write("gap_w1", 12'd1, 8'hBB);
        in_data = 8'hCC; step();
        chk_write("gap_w2", 12'd2, 8'hCC);
        in_data = 8'hCF; step();
        chk("gap_done", 32'(done), 32'd1);
        in_valid = 1'b0; step();
        chk("gap_wr_count", 32'(wr_count), 32'd3);
        chk("gap_mem", {8'h00, tbmem[2], tbmem[1], tbmem[0]}, 32'h00CC_BBAA);

        // Start during LOAD with a different len is ignored
        wr_count = 0;
        do_start(13'd2);
        in_valid = 1'b1; in_data = 8'h01;
        start = 1'b1; len = 13'd5;
        step();
        start = 1'b0;
        in_data = 8'h02; step();
        chk_write("ign_w1", 12'd1, 8'h02);
        in_data = 8'hFD; step();
        chk("ign_done", 32'(done), 32'd1);
        in_valid = 1'b0; step();
        chk("ign_wr_count", 32'(wr_count), 32'd2);

        // Full 4096-byte load wraps the address
        wr_count = 0;
        csum = 8'h00;
        do_start(13'd4096);
        in_valid = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            in_data = 8'(i * 3 + 1);
            csum = csum + in_data;
            step();
        end
        last_byte = 8'(4095 * 3 + 1);
        chk_write("full_last", 12'hFFF, last_byte);
        chk("full_check_ready", 32'(in_ready), 32'd1);
        in_data = 8'(8'h00 - csum); step();
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(err), 32'd0);
        in_valid = 1'b0; step();
        chk("full_wr_count", 32'(wr_count), 32'd4096);
        chk("full_we_after", 32'(mem_we), 32'd0);
        chk("full_mem0", 32'(tbmem[0]), 32'h01);
        chk("full_mem4095", 32'(tbmem[4095]), 32'hFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
